// File: rtl/usb_spi_arbiter_pkg.sv
// Shared types and helpers for the MAX3421E SPI arbiter: FSM states, command
// byte builder and the commonly used chip register numbers.
package usb_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_e;

  localparam logic [4:0] rHIRQ = 5'd25;
  localparam logic [4:0] rMODE = 5'd27;
  localparam logic [4:0] rHCTL = 5'd29;
  localparam logic [4:0] rHRSL = 5'd31;

  // MAX3421E command byte: register number, a zero, the direction bit, then ACKSTAT=0.
  function automatic logic [7:0] max_cmd(input logic [4:0] addr, input logic wr);
    return {addr, 1'b0, wr, 1'b0};
  endfunction

endpackage

// File: rtl/usb_spi_arbiter_tick_gen.sv
// Phase timer for the SPI engine: pulses tick once every CLK_DIV clocks and
// restarts its count whenever clr is asserted (on every FSM state entry).
module spi_tick_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(CLK_DIV - 1));

  always_comb begin
    cnt_d = (clr || tick) ? '0 : cnt_q + CW'(1);
  end

  // NOTE: sequential state is written only with non-blocking assignments so every
  // flop samples the pre-edge values of its neighbours.
  always_ff @(posedge Clk) begin
    if (Reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/usb_spi_arbiter.sv
// Round-robin arbiter sharing one MAX3421E SPI link between two requesters; each
// grant runs one 2-byte register access (mode 0, MSB first) and returns both rx bytes.
module usb_spi_arbiter
  import usb_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [1:0]  req,
  input  logic [1:0]  req_wr,
  input  logic [9:0]  req_addr,
  input  logic [15:0] req_wdata,
  output logic [1:0]  done,
  output logic [7:0]  rdata,
  output logic [7:0]  status,
  output logic        busy,
  input  logic        spi_MISO,
  output logic        spi_MOSI,
  output logic        spi_SCLK,
  output logic        spi_SS_n
);

  state_e      state_q, state_d;
  logic        port_q, port_d;
  logic        last_grant_q, last_grant_d;
  logic [15:0] shift_q, shift_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic        sclk_q, sclk_d;
  logic        rx_bit_q, rx_bit_d;
  logic [1:0]  done_q, done_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [7:0]  status_q, status_d;

  logic        tick;
  logic        sel;
  logic        sel_wr;
  logic [4:0]  sel_addr;
  logic [7:0]  sel_wdata;

  spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .Clk  (Clk),
    .Reset(Reset),
    .clr  (state_d != state_q),
    .tick (tick)
  );

  // Contention goes to the port that did not win last time.
  assign sel       = (req == 2'b11) ? ~last_grant_q : req[1];
  assign sel_wr    = sel ? req_wr[1] : req_wr[0];
  assign sel_addr  = sel ? req_addr[9:5] : req_addr[4:0];
  assign sel_wdata = sel ? req_wdata[15:8] : req_wdata[7:0];

  always_comb begin
    // NOTE: every next-state signal takes its hold value first so no path can
    // leave it unassigned and infer a latch.
    state_d      = state_q;
    port_d       = port_q;
    last_grant_d = last_grant_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    sclk_d       = sclk_q;
    rx_bit_d     = rx_bit_q;
    done_d       = 2'b00;
    rdata_d      = rdata_q;
    status_d     = status_q;

    unique case (state_q)
      IDLE: begin
        if (|req) begin
          port_d  = sel;
          shift_d = {max_cmd(sel_addr, sel_wr), sel_wr ? sel_wdata : 8'h00};
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (tick) begin
          bit_cnt_d = 4'd15;
          sclk_d    = 1'b0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (!sclk_q) begin
            sclk_d   = 1'b1;
            rx_bit_d = spi_MISO;
          end else begin
            // Received bits enter at the bottom as transmitted bits leave the top.
            sclk_d  = 1'b0;
            shift_d = {shift_q[14:0], rx_bit_q};
            if (bit_cnt_q == 4'd0) state_d = HOLD;
            else                   bit_cnt_d = bit_cnt_q - 4'd1;
          end
        end
      end
      HOLD: begin
        if (tick) begin
          done_d       = port_q ? 2'b10 : 2'b01;
          status_d     = shift_q[15:8];
          rdata_d      = shift_q[7:0];
          last_grant_d = port_q;
          state_d      = GAP;
        end
      end
      GAP: begin
        if (tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= IDLE;
      port_q       <= 1'b0;
      last_grant_q <= 1'b1;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      sclk_q       <= 1'b0;
      rx_bit_q     <= 1'b0;
      done_q       <= '0;
      rdata_q      <= '0;
      status_q     <= '0;
    end else begin
      state_q      <= state_d;
      port_q       <= port_d;
      last_grant_q <= last_grant_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      sclk_q       <= sclk_d;
      rx_bit_q     <= rx_bit_d;
      done_q       <= done_d;
      rdata_q      <= rdata_d;
      status_q     <= status_d;
    end
  end

  assign spi_SS_n = !(state_q == SETUP || state_q == SHIFT || state_q == HOLD);
  assign spi_SCLK = sclk_q;
  assign spi_MOSI = (state_q == SETUP || state_q == SHIFT) ? shift_q[15] : 1'b0;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign rdata    = rdata_q;
  assign status   = status_q;

endmodule
